// File: rtl/itcm_auto_loader_if.sv
// AXI4-lite bus bundle between the ITCM auto-loader (master) and the fabric
// (slave).
// Ports: AW/W/B write channels, AR/R read channels.
//
// Valid/ready semantics on every channel: a transfer completes on the rising
// edge where VALID and READY are both high. A source that raises VALID keeps
// it high, with its payload unchanged, until that edge. VALID never waits for
// READY. READY may depend on VALID.
interface itcm_auto_loader_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/itcm_auto_loader.sv
// ITCM auto-loader: an AXI4-lite master that copies LOAD_WORDS 32-bit words
// from the flash window (SRC_BASE) into the ITCM window (DST_BASE). It runs
// one read and then one write per word, with a single transaction in flight.
// Ports:
//   ACLK, ARESET    clock, synchronous active-high reset
//   start           one-cycle copy request, accepted only when idle
//   itcm_auto_load  high while a copy runs, so the slave blocks normal ITCM access
//   load_done       one-cycle pulse when a copy ends (finished or aborted)
//   load_error      sticky error flag for any non-OKAY response; cleared by start
//   dbg_state       current FSM state (IDLE=0 .. DONE=5)
//   axi             AXI4-lite master port
module itcm_auto_loader #(
  parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
  parameter logic [31:0] DST_BASE   = 32'h0000_0000,
  parameter int unsigned LOAD_WORDS = 1024,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start,
  output logic               itcm_auto_load,
  output logic               load_done,
  output logic               load_error,
  output logic [2:0]         dbg_state,
  itcm_auto_loader_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LOAD_N = CNT_WIDTH'(LOAD_WORDS);

  state_t               state_q, state_d;
  logic [31:0]          rd_addr_q, rd_addr_d;
  logic [31:0]          wr_addr_q, wr_addr_d;
  logic [31:0]          data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 aw_now;
  logic                 w_now;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    cnt_inc   = cnt_q + CNT_WIDTH'(1);
    // A write channel counts as done once its handshake happened, in this
    // cycle or in an earlier one.
    aw_now    = aw_done_q | (awvalid_q & axi.AWREADY);
    w_now     = w_done_q | (wvalid_q & axi.WREADY);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d = SRC_BASE;
          wr_addr_d = DST_BASE;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = (LOAD_N == '0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && axi.ARREADY) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (axi.RVALID) begin
          data_d = axi.RDATA;
          if (axi.RRESP != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi.BVALID) begin
          if (axi.BRESP != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d     = cnt_inc;
            rd_addr_d = rd_addr_q + 32'd4;
            wr_addr_d = wr_addr_q + 32'd4;
            state_d   = (cnt_inc == LOAD_N) ? S_DONE : S_RD_ADDR;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state, so each one is valid in
    // the same cycle as the state it belongs to.
    arvalid_d = (state_d == S_RD_ADDR);
    rready_d  = (state_d == S_RD_DATA);
    awvalid_d = (state_d == S_WR_REQ) && !aw_done_d;
    wvalid_d  = (state_d == S_WR_REQ) && !w_done_d;
    bready_d  = (state_d == S_WR_RESP);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign axi.ARVALID    = arvalid_q;
  assign axi.ARADDR     = rd_addr_q;
  assign axi.ARPROT     = 3'b000;
  assign axi.RREADY     = rready_q;
  assign axi.AWVALID    = awvalid_q;
  assign axi.AWADDR     = wr_addr_q;
  assign axi.AWPROT     = 3'b000;
  assign axi.WVALID     = wvalid_q;
  assign axi.WDATA      = data_q;
  assign axi.WSTRB      = 4'hF;
  assign axi.BREADY     = bready_q;
  assign itcm_auto_load = busy_q;
  assign load_done      = done_q;
  assign load_error     = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_itcm_auto_loader.sv
// Bench for itcm_auto_loader. It builds three loaders on a shared clock and
// reset: g_s[0] copies 4 words, g_s[1] copies 8 words, and g_s[2] copies 0
// words. Each loader has its own AXI slave model: the flash word at index i
// is 0x11111111*(i+1), stalls are optional, and an error response can be
// injected on a chosen word.
module tb_itcm_auto_loader;
  localparam logic [31:0] SRC = 32'h2000_0000;
  localparam logic [31:0] DST = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic     start_v   [3];
  logic     stall_en  [3];
  int       rerr_word [3];
  int       berr_word [3];
  wire       busy_w [3];
  wire       done_w [3];
  wire       err_w  [3];
  wire [2:0] st_w   [3];

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    return 32'h1111_1111 * ((a - SRC) >> 2) + 32'h1111_1111;
  endfunction

  function automatic int pick(input logic en);
    return en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_s
    localparam int unsigned NW = (g == 0) ? 4 : ((g == 1) ? 8 : 0);
    itcm_auto_loader_if axi ();
    itcm_auto_loader #(
      .SRC_BASE(SRC), .DST_BASE(DST), .LOAD_WORDS(NW), .CNT_WIDTH(16)
    ) u_dut (
      .ACLK(clk), .ARESET(rst), .start(start_v[g]),
      .itcm_auto_load(busy_w[g]), .load_done(done_w[g]),
      .load_error(err_w[g]), .dbg_state(st_w[g]), .axi(axi)
    );

    // Handshakes sampled on the rising edge; the negedge block acts on them.
    logic e_rst = 1'b1;
    logic e_ar = 1'b0, e_r = 1'b0, e_aw = 1'b0, e_w = 1'b0, e_b = 1'b0;
    logic e_arv = 1'b0, e_awv = 1'b0, e_wv = 1'b0;
    logic [31:0] e_araddr = '0, e_awaddr = '0, e_wdata = '0;
    int valid_seen = 0, stab_err = 0, prot_err = 0;

    always @(posedge clk) begin
      if (!rst && !e_rst) begin
        if (e_arv && !e_ar && (!axi.ARVALID || axi.ARADDR !== e_araddr)) stab_err++;
        if (e_awv && !e_aw && (!axi.AWVALID || axi.AWADDR !== e_awaddr)) stab_err++;
        if (e_wv && !e_w && (!axi.WVALID || axi.WDATA !== e_wdata)) stab_err++;
      end
      if (!rst) begin
        if (axi.ARVALID || axi.AWVALID || axi.WVALID || axi.RREADY || axi.BREADY) valid_seen++;
        if (axi.ARVALID && axi.ARPROT !== 3'b000) prot_err++;
        if (axi.AWVALID && axi.AWPROT !== 3'b000) prot_err++;
        if (axi.WVALID && axi.WSTRB !== 4'hF) prot_err++;
      end
      e_rst    = rst;
      e_ar     = axi.ARVALID && axi.ARREADY;
      e_r      = axi.RVALID && axi.RREADY;
      e_aw     = axi.AWVALID && axi.AWREADY;
      e_w      = axi.WVALID && axi.WREADY;
      e_b      = axi.BVALID && axi.BREADY;
      e_arv    = axi.ARVALID;
      e_awv    = axi.AWVALID;
      e_wv     = axi.WVALID;
      e_araddr = axi.ARADDR;
      e_awaddr = axi.AWADDR;
      e_wdata  = axi.WDATA;
    end

    logic rd_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] rd_addr = '0, aw_addr = '0, w_data = '0, b_addr = '0;
    int ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
    int ar_cnt = 0, wr_cnt = 0;
    logic [31:0] ar_addr_a [64];
    logic [31:0] wr_addr_a [64];
    logic [31:0] wr_data_a [64];

    always @(negedge clk) begin
      if (e_rst) begin
        rd_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
      end else begin
        if (e_ar) begin
          if (ar_cnt < 64) ar_addr_a[ar_cnt] = e_araddr;
          ar_cnt++;
          rd_addr = e_araddr; rd_pend = 1'b1;
          r_wait = pick(stall_en[g]); ar_wait = pick(stall_en[g]);
        end
        if (e_r) rd_pend = 1'b0;
        if (e_b) b_pend = 1'b0;
        if (e_aw) begin aw_got = 1'b1; aw_addr = e_awaddr; aw_wait = pick(stall_en[g]); end
        if (e_w) begin w_got = 1'b1; w_data = e_wdata; w_wait = pick(stall_en[g]); end
        if (aw_got && w_got) begin
          if (wr_cnt < 64) begin wr_addr_a[wr_cnt] = aw_addr; wr_data_a[wr_cnt] = w_data; end
          wr_cnt++;
          b_addr = aw_addr; b_pend = 1'b1; b_wait = pick(stall_en[g]);
          aw_got = 1'b0; w_got = 1'b0;
        end
        axi.ARREADY = axi.ARVALID && ar_wait == 0;
        if (axi.ARVALID && ar_wait > 0) ar_wait--;
        axi.AWREADY = axi.AWVALID && aw_wait == 0;
        if (axi.AWVALID && aw_wait > 0) aw_wait--;
        axi.WREADY = axi.WVALID && w_wait == 0;
        if (axi.WVALID && w_wait > 0) w_wait--;
        axi.RVALID = rd_pend && r_wait == 0;
        if (rd_pend && r_wait > 0) r_wait--;
        axi.RDATA = flash_word(rd_addr);
        axi.RRESP = (int'((rd_addr - SRC) >> 2) == rerr_word[g]) ? 2'b10 : 2'b00;
        axi.BVALID = b_pend && b_wait == 0;
        if (b_pend && b_wait > 0) b_wait--;
        axi.BRESP = (int'((b_addr - DST) >> 2) == berr_word[g]) ? 2'b11 : 2'b00;
      end
    end
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    start_v[g] = 1'b0;
  endtask

  // Counts cycles from the first negedge after the start edge (cycle 1).
  task automatic wait_done(input int g, input int budget, output int done_cyc,
                           output int pulses, output int busy_first,
                           output int busy_last, output int busy_cnt);
    done_cyc = 0; pulses = 0; busy_first = 0; busy_last = 0; busy_cnt = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (done_w[g]) begin
        pulses++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy_w[g]) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
    end
  endtask

  int dc, pc, bf, bl, bc, bw, ba, bv;
  logic found;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; stall_en[i] = 1'b0; rerr_word[i] = -1; berr_word[i] = -1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_done", 32'(done_w[0]), 32'd0);
    check("rst_err", 32'(err_w[0]), 32'd0);
    check("rst_state", 32'(st_w[0]), 32'd0);
    check("rst_arvalid", 32'(g_s[0].axi.ARVALID), 32'd0);
    check("rst_awvalid", 32'(g_s[0].axi.AWVALID), 32'd0);
    rst = 1'b0;

    // Test 1: 4-word copy with zero-wait slave
    bw = g_s[0].wr_cnt;
    pulse_start(0);
    wait_done(0, 20, dc, pc, bf, bl, bc);
    check("t1_done_cycle", 32'(dc), 32'd17);
    check("t1_done_pulses", 32'(pc), 32'd1);
    check("t1_busy_first", 32'(bf), 32'd1);
    check("t1_busy_last", 32'(bl), 32'd16);
    check("t1_busy_cnt", 32'(bc), 32'd16);
    check("t1_err", 32'(err_w[0]), 32'd0);
    check("t1_writes", 32'(g_s[0].wr_cnt - bw), 32'd4);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h1111_1111 * 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      check("t1_wdata", g_s[0].wr_data_a[bw + i], exp_q.pop_front());
      check("t1_waddr", g_s[0].wr_addr_a[bw + i], DST + 32'(4 * i));
    end
    check("t1_prot", 32'(g_s[0].prot_err), 32'd0);

    // Test 2: 8-word copy with random stalls on every channel
    stall_en[1] = 1'b1;
    bw = g_s[1].wr_cnt;
    pulse_start(1);
    wait_done(1, 400, dc, pc, bf, bl, bc);
    check("t2_done_seen", 32'(dc != 0), 32'd1);
    check("t2_done_pulses", 32'(pc), 32'd1);
    check("t2_writes", 32'(g_s[1].wr_cnt - bw), 32'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h1111_1111 * 32'(i + 1));
    for (int i = 0; i < 8; i++) begin
      check("t2_wdata", g_s[1].wr_data_a[bw + i], exp_q.pop_front());
      check("t2_waddr", g_s[1].wr_addr_a[bw + i], DST + 32'(4 * i));
    end
    check("t2_stable", 32'(g_s[1].stab_err), 32'd0);
    check("t2_prot", 32'(g_s[1].prot_err), 32'd0);
    check("t2_err", 32'(err_w[1]), 32'd0);

    // Test 3: SLVERR read response on word 2, then a clean rerun
    rerr_word[0] = 2;
    bw = g_s[0].wr_cnt; ba = g_s[0].ar_cnt;
    pulse_start(0);
    wait_done(0, 30, dc, pc, bf, bl, bc);
    check("t3_done_cycle", 32'(dc), 32'd11);
    check("t3_done_pulses", 32'(pc), 32'd1);
    check("t3_busy_last", 32'(bl), 32'd10);
    check("t3_err", 32'(err_w[0]), 32'd1);
    check("t3_writes", 32'(g_s[0].wr_cnt - bw), 32'd2);
    check("t3_reads", 32'(g_s[0].ar_cnt - ba), 32'd3);
    rerr_word[0] = -1;
    bw = g_s[0].wr_cnt;
    pulse_start(0);
    @(negedge clk);
    check("t3_err_cleared", 32'(err_w[0]), 32'd0);
    wait_done(0, 30, dc, pc, bf, bl, bc);
    check("t3_rerun_pulses", 32'(pc), 32'd1);
    check("t3_rerun_writes", 32'(g_s[0].wr_cnt - bw), 32'd4);
    check("t3_rerun_err", 32'(err_w[0]), 32'd0);

    // Test 4: DECERR write response on word 0
    berr_word[0] = 0;
    bw = g_s[0].wr_cnt; ba = g_s[0].ar_cnt;
    pulse_start(0);
    wait_done(0, 12, dc, pc, bf, bl, bc);
    check("t4_done_cycle", 32'(dc), 32'd5);
    check("t4_err", 32'(err_w[0]), 32'd1);
    check("t4_writes", 32'(g_s[0].wr_cnt - bw), 32'd1);
    berr_word[0] = -1;
    repeat (5) @(negedge clk);
    check("t4_reads", 32'(g_s[0].ar_cnt - ba), 32'd1);

    // Test 5: zero-length copy, then a start ignored while busy
    bv = g_s[2].valid_seen;
    pulse_start(2);
    wait_done(2, 4, dc, pc, bf, bl, bc);
    check("t5_done_cycle", 32'(dc), 32'd1);
    check("t5_done_pulses", 32'(pc), 32'd1);
    check("t5_busy_cnt", 32'(bc), 32'd0);
    check("t5_no_axi", 32'(g_s[2].valid_seen - bv), 32'd0);
    check("t5_no_reads", 32'(g_s[2].ar_cnt), 32'd0);
    bw = g_s[0].wr_cnt; ba = g_s[0].ar_cnt;
    pulse_start(0);
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, 30, dc, pc, bf, bl, bc);
    check("t5_busy_done_cycle", 32'(dc), 32'd15);
    check("t5_busy_pulses", 32'(pc), 32'd1);
    check("t5_busy_writes", 32'(g_s[0].wr_cnt - bw), 32'd4);
    check("t5_busy_reads", 32'(g_s[0].ar_cnt - ba), 32'd4);

    // Test 6: reset while the write request is pending
    bw = g_s[0].wr_cnt;
    pulse_start(0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (st_w[0] == 3'd3 && g_s[0].axi.AWVALID) found = 1'b1;
    end
    check("t6_reached_wr_req", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_arvalid", 32'(g_s[0].axi.ARVALID), 32'd0);
    check("t6_awvalid", 32'(g_s[0].axi.AWVALID), 32'd0);
    check("t6_wvalid", 32'(g_s[0].axi.WVALID), 32'd0);
    check("t6_rready", 32'(g_s[0].axi.RREADY), 32'd0);
    check("t6_bready", 32'(g_s[0].axi.BREADY), 32'd0);
    check("t6_busy", 32'(busy_w[0]), 32'd0);
    check("t6_done", 32'(done_w[0]), 32'd0);
    check("t6_state", 32'(st_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_no_write", 32'(g_s[0].wr_cnt - bw), 32'd0);
    ba = g_s[0].ar_cnt;
    pulse_start(0);
    wait_done(0, 30, dc, pc, bf, bl, bc);
    check("t6_restart_pulses", 32'(pc), 32'd1);
    check("t6_restart_araddr", g_s[0].ar_addr_a[ba], SRC);
    check("t6_restart_writes", 32'(g_s[0].wr_cnt - bw), 32'd4);
    check("t6_restart_wdata", g_s[0].wr_data_a[bw], 32'h1111_1111);
    check("t6_restart_waddr", g_s[0].wr_addr_a[bw], DST);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
